// File: rtl/dep_chk_pipe.sv
// dep_chk_pipe: registered rename dependency checker with in-group and stage1-group forwarding.
module dep_chk_pipe #(
  parameter int WIDTH       = 4,
  parameter int AREG_W      = 5,
  parameter int IDX_W       = $clog2(WIDTH),
  parameter int ZERO_REG_EN = 1,
  parameter int ZERO_REG    = 31
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        in_vld_i,
  output logic                        in_rdy_o,
  input  logic [WIDTH-1:0]            slot_vld_i,
  input  logic [WIDTH*AREG_W-1:0]     ars1_i,
  input  logic [WIDTH*AREG_W-1:0]     ars2_i,
  input  logic [WIDTH*AREG_W-1:0]     ard_i,
  input  logic [WIDTH-1:0]            ard_vld_i,
  output logic                        out_vld_o,
  input  logic                        out_rdy_i,
  output logic [WIDTH*(2+IDX_W)-1:0]  rs1_sel_o,
  output logic [WIDTH*(2+IDX_W)-1:0]  rs2_sel_o,
  output logic [WIDTH*(2+IDX_W)-1:0]  rd_sel_o,
  output logic [WIDTH-1:0]            last_wr_o,
  output logic [WIDTH-1:0]            slot_vld_o
);
  localparam int SW = 2 + IDX_W;
  localparam logic [AREG_W-1:0] ZR = AREG_W'(ZERO_REG);
  logic                    out_vld_q, in_fire, out_fire;
  logic [WIDTH*SW-1:0]     sel_d [3];
  logic [WIDTH*SW-1:0]     sel_q [3];
  logic [WIDTH-1:0]        prod, last_wr_d, last_wr_q, slot_vld_q, prev_prod_q;
  logic [WIDTH*AREG_W-1:0] prev_ard_q;
  logic [AREG_W-1:0]       src;
  assign in_rdy_o   = !out_vld_q || out_rdy_i;
  assign in_fire    = in_vld_i && in_rdy_o;
  assign out_fire   = out_vld_q && out_rdy_i;
  assign out_vld_o  = out_vld_q;
  assign rs1_sel_o  = sel_q[0];
  assign rs2_sel_o  = sel_q[1];
  assign rd_sel_o   = sel_q[2];
  assign last_wr_o  = last_wr_q;
  assign slot_vld_o = slot_vld_q;
  always_comb begin
    src = '0;
    for (int k = 0; k < WIDTH; k++)
      prod[k] = slot_vld_i[k] && ard_vld_i[k] &&
                !(ZERO_REG_EN != 0 && ard_i[k*AREG_W +: AREG_W] == ZR);
    for (int k = 0; k < WIDTH; k++) begin
      last_wr_d[k] = prod[k];
      for (int j = 0; j < WIDTH; j++)
        if (j > k && prod[j] && ard_i[j*AREG_W +: AREG_W] == ard_i[k*AREG_W +: AREG_W])
          last_wr_d[k] = 1'b0;
    end
    // Ascending scans let the youngest match win; in-group hits override stage1 hits.
    for (int s = 0; s < 3; s++) begin
      sel_d[s] = '0;
      for (int k = 0; k < WIDTH; k++) begin
        src = s == 0 ? ars1_i[k*AREG_W +: AREG_W] :
              s == 1 ? ars2_i[k*AREG_W +: AREG_W] : ard_i[k*AREG_W +: AREG_W];
        sel_d[s][k*SW +: SW] = {2'b00, IDX_W'(k)};
        for (int p = 0; p < WIDTH; p++)
          if (out_vld_q && prev_prod_q[p] && prev_ard_q[p*AREG_W +: AREG_W] == src)
            sel_d[s][k*SW +: SW] = {2'b10, IDX_W'(p)};
        for (int j = 0; j < WIDTH; j++)
          if (j < k && prod[j] && ard_i[j*AREG_W +: AREG_W] == src)
            sel_d[s][k*SW +: SW] = {2'b01, IDX_W'(j)};
        if (ZERO_REG_EN != 0 && src == ZR)
          sel_d[s][k*SW +: SW] = '0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q   <= 1'b0;
      sel_q[0]    <= '0;
      sel_q[1]    <= '0;
      sel_q[2]    <= '0;
      last_wr_q   <= '0;
      slot_vld_q  <= '0;
      prev_prod_q <= '0;
      prev_ard_q  <= '0;
    end else begin
      out_vld_q <= flush_i ? 1'b0 : in_fire ? 1'b1 : out_fire ? 1'b0 : out_vld_q;
      if (in_fire && !flush_i) begin
        sel_q[0]    <= sel_d[0];
        sel_q[1]    <= sel_d[1];
        sel_q[2]    <= sel_d[2];
        last_wr_q   <= last_wr_d;
        slot_vld_q  <= slot_vld_i;
        prev_prod_q <= prod;
        prev_ard_q  <= ard_i;
      end
    end
  end
endmodule
